// File: rtl/clock_display_scan_pkg.sv
// clock_disp_pkg: digit count, segment patterns and separator mask shared by the display scanner
package clock_disp_pkg;
    localparam int NUM_DIGITS = 6;
    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;
endpackage

// File: rtl/clock_display_scan_if.sv
// clock_display_scan_if: counter-side digits/controls in, display pin drives out
interface clock_display_scan_if;
    import clock_disp_pkg::*;
    logic En;
    bcd_t D0, D1, D2, D3, D4, D5;
    logic Blank_lz;
    logic Blink_en;
    logic [NUM_DIGITS-1:0] Blink_mask;
    seg_t Seg;
    logic Dp;
    logic [NUM_DIGITS-1:0] An;
    logic Frame_tick;
    modport master(
        output En, D0, D1, D2, D3, D4, D5, Blank_lz, Blink_en, Blink_mask,
        input Seg, Dp, An, Frame_tick
    );
    modport slave(
        input En, D0, D1, D2, D3, D4, D5, Blank_lz, Blink_en, Blink_mask,
        output Seg, Dp, An, Frame_tick
    );
endinterface

// File: rtl/clock_display_scan_bcd_to_seg.sv
// bcd_to_seg: active-high {g,f,e,d,c,b,a} pattern for a BCD digit; codes above 9 go dark
module bcd_to_seg
    import clock_disp_pkg::*;
(
    input bcd_t bcd,
    output seg_t seg
);
    localparam seg_t LUT [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
    assign seg = bcd < 4'd10 ? LUT[bcd] : SEG_BLANK;
endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: time-multiplexes six shadowed BCD digits onto a common-anode display
// with leading-zero blanking, set-mode blinking and HH.MM.SS separators.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLINK_FRAMES = 40,
    parameter bit ACTIVE_LOW = 1
) (
    input logic Clk,
    input logic Clr,
    clock_display_scan_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
    localparam seg_t SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [PW-1:0] presc;
    logic [2:0] idx, nidx;
    bcd_t shadow [NUM_DIGITS];
    bcd_t d_in [NUM_DIGITS];
    logic [FW-1:0] fcnt, nfcnt;
    logic phase, nphase, step, snap, blank, wrap;
    bcd_t digit;
    seg_t raw, seg_n, seg_q;
    logic dp_q, ft_q;
    logic [NUM_DIGITS-1:0] an_q;

    assign d_in = '{bus.D0, bus.D1, bus.D2, bus.D3, bus.D4, bus.D5};
    assign step = bus.En && presc == PW'(SCAN_DIV - 1);
    assign snap = step && idx == LAST;
    assign nidx = step ? (idx == LAST ? 3'd0 : idx + 3'd1) : idx;
    assign wrap = fcnt == FW'(BLINK_FRAMES - 1);

    always_comb begin
        nfcnt = fcnt;
        nphase = phase;
        if (!bus.Blink_en) begin
            nfcnt = '0;
            nphase = 1'b0;
        end else if (snap) begin
            nfcnt = wrap ? '0 : fcnt + 1'b1;
            nphase = wrap ? ~phase : phase;
        end
    end

    // on the snapshot edge digit 0 must already show the freshly captured value
    assign digit = snap ? d_in[nidx] : shadow[nidx];

    bcd_to_seg u_dec (
        .bcd(digit),
        .seg(raw)
    );

    assign blank = (nidx == LAST && bus.Blank_lz && digit == 4'd0)
                || (bus.Blink_en && nphase && bus.Blink_mask[nidx]);
    assign seg_n = blank ? SEG_BLANK : raw;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            presc <= '0;
            idx <= LAST;
            shadow <= '{default: '0};
            fcnt <= '0;
            phase <= 1'b0;
        end else begin
            fcnt <= nfcnt;
            phase <= nphase;
            if (bus.En) begin
                presc <= step ? '0 : presc + 1'b1;
                idx <= nidx;
            end
            if (snap) shadow <= d_in;
        end
    end

    // polarity is folded in here so the pins come straight from flops
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            seg_q <= SEG_OFF;
            dp_q <= ACTIVE_LOW;
            an_q <= AN_OFF;
            ft_q <= 1'b0;
        end else begin
            seg_q <= (bus.En ? seg_n : SEG_BLANK) ^ SEG_OFF;
            dp_q <= (bus.En && DP_MASK[nidx]) ^ ACTIVE_LOW;
            an_q <= (bus.En ? AN_ONE << nidx : '0) ^ AN_OFF;
            ft_q <= snap;
        end
    end

    assign bus.Seg = seg_q;
    assign bus.Dp = dp_q;
    assign bus.An = an_q;
    assign bus.Frame_tick = ft_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: random stimulus against a cycle-count reference model,
// driving an active-high and an active-low instance from the same inputs.
module tb_clock_display_scan;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic Clk = 1'b0;
    logic Clr = 1'b0;
    logic en = 1'b1;
    logic blank_lz = 1'b0;
    logic blink_en = 1'b0;
    logic [5:0] mask = '0;
    logic [3:0] d [6] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    clock_display_scan_if b0();
    clock_display_scan_if b1();

    assign b0.En = en;
    assign b0.D0 = d[0];
    assign b0.D1 = d[1];
    assign b0.D2 = d[2];
    assign b0.D3 = d[3];
    assign b0.D4 = d[4];
    assign b0.D5 = d[5];
    assign b0.Blank_lz = blank_lz;
    assign b0.Blink_en = blink_en;
    assign b0.Blink_mask = mask;
    assign b1.En = en;
    assign b1.D0 = d[0];
    assign b1.D1 = d[1];
    assign b1.D2 = d[2];
    assign b1.D3 = d[3];
    assign b1.D4 = d[4];
    assign b1.D5 = d[5];
    assign b1.Blank_lz = blank_lz;
    assign b1.Blink_en = blink_en;
    assign b1.Blink_mask = mask;

    clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dut0 (
        .Clk(Clk), .Clr(Clr), .bus(b0)
    );
    clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut1 (
        .Clk(Clk), .Clr(Clr), .bus(b1)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: n enabled cycles since reset => n/SD steps; step k shows digit (k-1)%6
    int n = 0;
    int sh [6] = '{default: 0};
    int snaps = 0;
    int k, di, ph;
    bit stp, snp, blk;
    logic [6:0] e_seg = '0;
    logic e_dp = 1'b0;
    logic [5:0] e_an = '0;
    logic e_ft = 1'b0;
    logic [6:0] ni_seg;
    logic ni_dp;
    logic [5:0] ni_an;
    assign ni_seg = ~e_seg;
    assign ni_dp = ~e_dp;
    assign ni_an = ~e_an;

    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            n = 0;
            snaps = 0;
            for (int i = 0; i < 6; i++) sh[i] = 0;
            e_seg = '0;
            e_dp = 1'b0;
            e_an = '0;
            e_ft = 1'b0;
        end else begin
            if (!blink_en) snaps = 0;
            if (!en) begin
                e_seg = '0;
                e_dp = 1'b0;
                e_an = '0;
                e_ft = 1'b0;
            end else begin
                n++;
                k = n / SD;
                stp = (n % SD) == 0;
                di = (k + 5) % 6;
                snp = stp && di == 0;
                if (snp) begin
                    for (int i = 0; i < 6; i++) sh[i] = int'(d[i]);
                    if (blink_en) snaps++;
                end
                ph = (snaps / BF) % 2;
                blk = (di == 5 && blank_lz && sh[5] == 0) || (blink_en && ph == 1 && mask[di]);
                e_seg = blk ? 7'h00 : (sh[di] < 10 ? SEGS[sh[di]] : 7'h00);
                e_dp = di == 2 || di == 4;
                e_an = 6'(1) << di;
                e_ft = snp;
            end
        end
    end

    always @(negedge Clk) begin
        check("seg", b0.Seg, e_seg);
        check("dp", b0.Dp, e_dp);
        check("an", b0.An, e_an);
        check("ft", b0.Frame_tick, e_ft);
        check("seg_al", b1.Seg, ni_seg);
        check("dp_al", b1.Dp, ni_dp);
        check("an_al", b1.An, ni_an);
        check("ft_al", b1.Frame_tick, e_ft);
    end

    initial begin
        repeat (2) @(negedge Clk);
        check("rst_an", b0.An, 6'h00);
        check("rst_seg_al", b1.Seg, 7'h7F);
        check("rst_an_al", b1.An, 6'h3F);
        Clr = 1'b1;
        repeat (4) @(negedge Clk);
        check("first_an", b0.An, 6'b000001);
        check("first_seg", b0.Seg, 7'h7D);
        check("first_ft", b0.Frame_tick, 1'b1);
        repeat (4) @(negedge Clk);
        check("d1_an", b0.An, 6'b000010);
        check("d1_seg", b0.Seg, 7'h6D);
        repeat (16) @(negedge Clk);
        check("d5_an", b0.An, 6'b100000);
        check("d5_seg", b0.Seg, 7'h06);
        blink_en = 1'b1;
        mask = 6'b000011;
        blank_lz = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            if ($urandom_range(0, 11) == 0) d[$urandom_range(0, 5)] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 59) == 0) d[5] = 4'($urandom_range(0, 1));
            if ($urandom_range(0, 119) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 499) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 149) == 0) mask = 6'($urandom_range(0, 63));
            if (en) begin
                if ($urandom_range(0, 79) == 0) en = 1'b0;
            end else if ($urandom_range(0, 5) == 0) en = 1'b1;
        end
        en = 1'b1;
        for (int i = 0; i < 100 && b0.An != 6'b010000; i++) @(negedge Clk);
        check("wait_an4", b0.An, 6'b010000);
        #2 Clr = 1'b0;
        #1;
        check("clr_an", b0.An, 6'h00);
        check("clr_an_al", b1.An, 6'h3F);
        @(negedge Clk);
        Clr = 1'b1;
        repeat (4) @(negedge Clk);
        check("restart_an", b0.An, 6'b000001);
        check("restart_ft", b0.Frame_tick, 1'b1);
        repeat (30) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the clock counter's six BCD digits (sec units/tens, min units/tens, hr units/tens).
- Time-multiplexes them onto a 6-digit common-anode 7-segment display: refresh prescaler, digit scan, frame-coherent snapshot, BCD-to-segment decode, leading-zero blanking and set-mode blinking.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 50000, Clk cycles per digit slot (must be >= 2).
- BLINK_FRAMES, 40, full scan frames per blink half-period (>= 1).
- ACTIVE_LOW, 1, 1 = Seg, Dp and An driven active-low at the pins; 0 = active-high.

Ports:
- Clk  input  1  system clock.
- Clr  input  1  asynchronous reset, active-low.
- En  input  1  display enable; 0 = all anodes inactive and counters held.
- D0..D5  input  4 each  BCD digits, D0 = sec units … D5 = hr tens.
- Blank_lz  input  1  blank D5 when it is 0.
- Blink_en  input  1  enable blinking of masked digits.
- Blink_mask  input  6  bit i set = digit i blinks.
- Seg  output  7  {g,f,e,d,c,b,a}.
- Dp  output  1  decimal point.
- An  output  6  one-hot digit select, bit i drives digit i.
- Frame_tick  output  1  one-cycle pulse at snapshot instant.

Behaviour:
- Clock and reset: Clk, posedge; Clr asynchronous, active-low.
- Reset values:
  - Prescaler = 0; digit index = 5; shadow digits = 0; blink phase = 0; blink frame count = 0.
  - An, Seg, Dp all inactive (all 1 when ACTIVE_LOW = 1); Frame_tick = 0.
- Prescaler: counts 0..SCAN_DIV-1 while En = 1. A scan step occurs on the edge where the count = SCAN_DIV-1; the count then wraps to 0.
- Scan step:
  - Index advances 0→1→…→5→0.
  - Outputs are registered and reflect the new index from the same edge.
  - The first step after reset selects digit 0.
- Snapshot: on the step where the index goes 5→0, all six D inputs are captured into shadow registers and Frame_tick pulses for exactly that cycle. Digits only ever display shadow values, so no tearing within a frame.
- Decode (internal active-high), 0..9:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F (hex)
  - Codes 10..15 decode to blank (00).
- Blanking (segments 00, anode still active), applied in priority order:
  1. Blank_lz = 1 and the shadow D5 value = 0 → digit 5 blank.
  2. Blink_en = 1, blink phase = 1 and Blink_mask[i] = 1 → digit i blank.
- Dp: active on digits 2 and 4 (HH.MM.SS separators), inactive otherwise. Blinking never suppresses Dp.
- Blink:
  - Frame count increments at each snapshot; at BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - Blink_en = 0 forces the phase and count to 0 (first blank half starts a full half-period after enabling).
- En = 0:
  - On the next edge, An goes all inactive and Seg/Dp go inactive.
  - Prescaler, index, shadow and blink state hold.
  - When En returns to 1, scanning resumes from the held state; the current index is redisplayed on the first En = 1 edge.
- Polarity: ACTIVE_LOW inverts Seg, Dp and An at the output registers only.
- Blink_mask / Blink_en / Blank_lz are sampled live at each scan step, not snapshotted.
- Clr asserted mid-frame: immediate return to reset values; after release the display restarts at digit 0 following a fresh snapshot.

Decomposition:
- Package clock_disp_pkg:
  - NUM_DIGITS = 6.
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Dp digit mask constant (6'b010100).
- Sub-module bcd_to_seg: purely combinational 4-bit to 7-bit decoder, instantiated once on the muxed shadow digit.

Test Plan (SCAN_DIV = 4, BLINK_FRAMES = 2, ACTIVE_LOW = 0):
- Reset release with D5..D0 = 1,2,3,4,5,6, En = 1:
  - At cycle 4: Frame_tick pulses; An = 000001, Seg = 7D (6).
  - At cycle 8: An = 000010, Seg = 6D.
  - An = 100000 with Seg = 06 at cycle 24.
  - Dp high only while An = 000100 or 010000.
- Change D0 from 6 to 9 mid-frame (An = 001000): digit 0 still shows 7D until the next Frame_tick, then 6F.
- D5 = 0, Blank_lz = 1: An = 100000 with Seg = 00. With Blank_lz = 0: Seg = 3F. D3 = 12 → Seg = 00 on An = 001000.
- Blink_en = 1, Blink_mask = 000011:
  - Digits 0 and 1 show normal patterns for 2 frames, then 00 for 2 frames, repeating.
  - Digits 2..5 are unaffected; Dp still active on digit 2.
- En = 0 at An = 000100: next edge An = 000000, Seg = 00, Dp = 0. Re-enable 10 cycles later: An = 000100 resumes and the step occurs after the remaining prescaler count.
- Clr pulsed low while An = 010000: An = 000000 asynchronously. After release, the first step gives An = 000001 with Frame_tick; repeat the first scenario with ACTIVE_LOW = 1 and check all outputs are inverted.
